// File: rtl/wspe_db.sv
// ---------------------------------------------------------------------------
// wspe_db : weight-stationary MAC PE with shadow-weight daisy chain  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wspe_db #(
  parameter int A_W = 32,
  parameter int W_W = 32,
  parameter int P_W = 32,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clrPsum,
  input  logic [A_W-1:0] ipA,
  input  logic           ipAValid,
  output logic [A_W-1:0] opA,
  output logic           opAValid,
  input  logic [W_W-1:0] ipW,
  input  logic           ipWLoad,
  input  logic           ipWSwap,
  output logic [W_W-1:0] opW,
  input  logic [P_W-1:0] ipPsum,
  output logic [P_W-1:0] opPsum,
  output logic           opOvf,
  output logic           opWErr
);

  localparam int PROD_W = A_W + W_W;
  localparam int SUM_W  = ((PROD_W > P_W) ? PROD_W : P_W) + 1;

  logic [A_W-1:0]    a_q, a_d;
  logic              a_valid_q;
  logic [W_W-1:0]    shadow_q, shadow_d;
  logic              shadow_valid_q, shadow_valid_d;
  logic [W_W-1:0]    active_q, active_d;
  logic              active_valid_q, active_valid_d;
  logic [P_W-1:0]    psum_q, psum_d;
  logic              ovf_q, ovf_d;
  logic              werr_q, werr_d;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;
  logic              sum_ovf;
  logic [P_W-1:0]    mac_res;
  logic              do_swap;

  // Operands zero-extended so the sum carries every bit of the true result.
  always_comb begin
    prod    = {{W_W{1'b0}}, ipA} * {{A_W{1'b0}}, active_q};
    sum     = {{(SUM_W-PROD_W){1'b0}}, prod} + {{(SUM_W-P_W){1'b0}}, ipPsum};
    sum_ovf = |sum[SUM_W-1:P_W];
    if (sum_ovf && (SAT != 0)) begin
      mac_res = {P_W{1'b1}};
    end else begin
      mac_res = sum[P_W-1:0];
    end
  end

  always_comb begin
    do_swap        = ipWSwap && shadow_valid_q;
    a_d            = ipAValid ? ipA : a_q;
    shadow_d       = ipWLoad ? ipW : shadow_q;
    shadow_valid_d = shadow_valid_q;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    werr_d         = werr_q;
    if (do_swap) begin
      active_d       = shadow_q;
      active_valid_d = 1'b1;
      shadow_valid_d = 1'b0;
    end
    if (ipWSwap && !shadow_valid_q) werr_d = 1'b1;
    // A load in the same cycle as a swap refills the slot just vacated.
    if (ipWLoad) shadow_valid_d = 1'b1;

    psum_d = psum_q;
    ovf_d  = ovf_q;
    if (clrPsum) begin
      psum_d = '0;
      ovf_d  = 1'b0;
    end else if (ipAValid) begin
      psum_d = mac_res;
      ovf_d  = ovf_q | sum_ovf;
    end else begin
      psum_d = ipPsum;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q            <= '0;
      a_valid_q      <= 1'b0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      active_q       <= '0;
      active_valid_q <= 1'b0;
      psum_q         <= '0;
      ovf_q          <= 1'b0;
      werr_q         <= 1'b0;
    end else begin
      a_q            <= a_d;
      a_valid_q      <= ipAValid;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      active_q       <= active_d;
      active_valid_q <= active_valid_d;
      psum_q         <= psum_d;
      ovf_q          <= ovf_d;
      werr_q         <= werr_d;
    end
  end

  // activeValid is state only: an unarmed active register already reads 0.
  logic unused_ok;
  assign unused_ok = active_valid_q;

  assign opA      = a_q;
  assign opAValid = a_valid_q;
  assign opW      = shadow_q;
  assign opPsum   = psum_q;
  assign opOvf    = ovf_q;
  assign opWErr   = werr_q;

endmodule

`default_nettype wire

// File: tb/tb_wspe_db.sv
// ---------------------------------------------------------------------------
// tb_wspe_db : directed bench, 8-bit wrap / 8-bit saturate / 32-bit PEs | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wspe_db;

  logic        clk = 1'b0;
  logic        rstn, clrPsum, ipAValid, ipWLoad, ipWSwap;
  logic [31:0] ipA, ipW, ipPsum;

  logic [7:0]  w_opA, w_opW, w_opPsum;
  logic        w_opAValid, w_opOvf, w_opWErr;
  logic [7:0]  s_opA, s_opW, s_opPsum;
  logic        s_opAValid, s_opOvf, s_opWErr;
  logic [31:0] d_opA, d_opW, d_opPsum;
  logic        d_opAValid, d_opOvf, d_opWErr;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  wspe_db #(.A_W(8), .W_W(8), .P_W(8), .SAT(0)) u_wrap (
    .clk(clk), .rstn(rstn), .clrPsum(clrPsum),
    .ipA(ipA[7:0]), .ipAValid(ipAValid), .opA(w_opA), .opAValid(w_opAValid),
    .ipW(ipW[7:0]), .ipWLoad(ipWLoad), .ipWSwap(ipWSwap), .opW(w_opW),
    .ipPsum(ipPsum[7:0]), .opPsum(w_opPsum), .opOvf(w_opOvf), .opWErr(w_opWErr)
  );

  wspe_db #(.A_W(8), .W_W(8), .P_W(8), .SAT(1)) u_sat (
    .clk(clk), .rstn(rstn), .clrPsum(clrPsum),
    .ipA(ipA[7:0]), .ipAValid(ipAValid), .opA(s_opA), .opAValid(s_opAValid),
    .ipW(ipW[7:0]), .ipWLoad(ipWLoad), .ipWSwap(ipWSwap), .opW(s_opW),
    .ipPsum(ipPsum[7:0]), .opPsum(s_opPsum), .opOvf(s_opOvf), .opWErr(s_opWErr)
  );

  wspe_db u_def (
    .clk(clk), .rstn(rstn), .clrPsum(clrPsum),
    .ipA(ipA), .ipAValid(ipAValid), .opA(d_opA), .opAValid(d_opAValid),
    .ipW(ipW), .ipWLoad(ipWLoad), .ipWSwap(ipWSwap), .opW(d_opW),
    .ipPsum(ipPsum), .opPsum(d_opPsum), .opOvf(d_opOvf), .opWErr(d_opWErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " w_opA"},      32'(w_opA), 0);
    chk({tag, " w_opAValid"}, 32'(w_opAValid), 0);
    chk({tag, " w_opW"},      32'(w_opW), 0);
    chk({tag, " w_opPsum"},   32'(w_opPsum), 0);
    chk({tag, " w_opOvf"},    32'(w_opOvf), 0);
    chk({tag, " w_opWErr"},   32'(w_opWErr), 0);
    chk({tag, " d_opA"},      d_opA, 0);
    chk({tag, " d_opW"},      d_opW, 0);
    chk({tag, " d_opPsum"},   d_opPsum, 0);
    chk({tag, " s_opPsum"},   32'(s_opPsum), 0);
    chk({tag, " s_opWErr"},   32'(s_opWErr), 0);
  endtask

  initial begin
    rstn = 1'b0; clrPsum = 1'b0; ipAValid = 1'b0; ipWLoad = 1'b0; ipWSwap = 1'b0;
    ipA = '0; ipW = '0; ipPsum = '0;
    tick; tick;
    chk_all_zero("reset");
    rstn = 1'b1;

    // Build up state, then assert reset asynchronously mid-cycle.
    ipW = 32'd7; ipWLoad = 1'b1; ipPsum = 32'h1234;
    tick;
    ipWLoad = 1'b0;
    chk("pre-rst d_opPsum", d_opPsum, 32'h1234);
    chk("pre-rst w_opW", 32'(w_opW), 32'd7);
    #2 rstn = 1'b0;
    #1 chk_all_zero("async rst");
    #1 rstn = 1'b1;

    ipPsum = 32'd5; ipAValid = 1'b0;
    tick;
    chk("idle opPsum", 32'(w_opPsum), 32'd5);
    chk("idle d_opPsum", d_opPsum, 32'd5);
    chk("idle opAValid", 32'(w_opAValid), 0);

    // Swap while empty: sticky error, active stays 0.
    ipWSwap = 1'b1;
    tick;
    ipWSwap = 1'b0;
    chk("empty swap werr", 32'(w_opWErr), 1);
    chk("empty swap d_werr", 32'(d_opWErr), 1);
    ipA = 32'd5; ipAValid = 1'b1; ipPsum = 32'd1;
    tick;
    chk("empty mac opPsum", 32'(w_opPsum), 32'd1);
    chk("empty mac opA", 32'(w_opA), 32'd5);
    chk("empty mac opAValid", 32'(w_opAValid), 1);
    chk("empty mac ovf", 32'(w_opOvf), 0);
    clrPsum = 1'b1; ipAValid = 1'b0;
    tick;
    clrPsum = 1'b0;
    chk("clr keeps werr", 32'(w_opWErr), 1);
    chk("clr psum", 32'(w_opPsum), 0);
    chk("clr keeps opA", 32'(w_opA), 32'd5);

    // Load 3; swap coincides with first MAC, which still sees weight 0.
    ipW = 32'd3; ipWLoad = 1'b1;
    tick;
    ipWLoad = 1'b0;
    chk("load opW", 32'(w_opW), 32'd3);
    ipWSwap = 1'b1; ipA = 32'd7; ipAValid = 1'b1; ipPsum = 32'd10;
    tick;
    ipWSwap = 1'b0;
    chk("swap-edge mac", 32'(w_opPsum), 32'd10);
    chk("swap-edge d_mac", d_opPsum, 32'd10);
    tick;
    chk("mac 7*3+10", 32'(w_opPsum), 32'd31);
    chk("mac d 7*3+10", d_opPsum, 32'd31);
    chk("mac opA", 32'(w_opA), 32'd7);

    // ARMED active=3: preload 4, then load 9 together with swap.
    ipAValid = 1'b0; ipPsum = '0;
    ipW = 32'd4; ipWLoad = 1'b1;
    tick;
    chk("chain opW 4", 32'(w_opW), 32'd4);
    ipW = 32'd9; ipWSwap = 1'b1;
    tick;
    ipWLoad = 1'b0; ipWSwap = 1'b0;
    chk("load+swap opW", 32'(w_opW), 32'd9);
    ipA = 32'd2; ipAValid = 1'b1; ipPsum = 32'd0;
    tick;
    chk("load+swap mac", 32'(w_opPsum), 32'd8);
    ipWSwap = 1'b1; ipAValid = 1'b0;
    tick;
    ipWSwap = 1'b0;
    ipA = 32'd1; ipAValid = 1'b1;
    tick;
    chk("shadow was valid", 32'(w_opPsum), 32'd9);

    // Overflow boundary with weight 16.
    ipAValid = 1'b0;
    ipW = 32'd16; ipWLoad = 1'b1;
    tick;
    ipWLoad = 1'b0; ipWSwap = 1'b1;
    tick;
    ipWSwap = 1'b0;
    ipA = 32'd15; ipAValid = 1'b1; ipPsum = 32'd15;
    tick;
    chk("edge 255 wrap", 32'(w_opPsum), 32'd255);
    chk("edge 255 wrap ovf", 32'(w_opOvf), 0);
    chk("edge 255 sat", 32'(s_opPsum), 32'd255);
    chk("edge 255 sat ovf", 32'(s_opOvf), 0);
    ipA = 32'd16; ipPsum = 32'd1;
    tick;
    chk("ovf wrap psum", 32'(w_opPsum), 32'd1);
    chk("ovf wrap flag", 32'(w_opOvf), 1);
    chk("ovf sat psum", 32'(s_opPsum), 32'd255);
    chk("ovf sat flag", 32'(s_opOvf), 1);
    chk("no ovf 32b psum", d_opPsum, 32'd257);
    chk("no ovf 32b flag", 32'(d_opOvf), 0);
    ipA = 32'd0; ipPsum = 32'd2;
    tick;
    chk("sticky ovf psum", 32'(w_opPsum), 32'd2);
    chk("sticky ovf wrap", 32'(w_opOvf), 1);
    chk("sticky ovf sat", 32'(s_opOvf), 1);
    ipA = 32'd16; ipPsum = 32'd1; clrPsum = 1'b1;
    tick;
    clrPsum = 1'b0;
    chk("clr over mac psum", 32'(s_opPsum), 0);
    chk("clr ovf wrap", 32'(w_opOvf), 0);
    chk("clr ovf sat", 32'(s_opOvf), 0);
    chk("clr opA passes", 32'(w_opA), 32'd16);
    chk("clr opW kept", 32'(w_opW), 32'd16);

    // Bubble: opA holds, psum passes through.
    ipA = 32'd6; ipAValid = 1'b1; ipPsum = 32'd0;
    tick;
    chk("bubble pre psum", 32'(w_opPsum), 32'd96);
    chk("bubble pre opA", 32'(w_opA), 32'd6);
    ipA = 32'd99; ipAValid = 1'b0; ipPsum = 32'h77;
    tick;
    chk("bubble opA hold", 32'(w_opA), 32'd6);
    chk("bubble opAValid", 32'(w_opAValid), 0);
    chk("bubble psum", 32'(w_opPsum), 32'h77);
    chk("bubble d_psum", d_opPsum, 32'h77);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
